// File: rtl/pixel_readout.sv
// Two-row pixel readout: captures one converted row per ADC strobe after an
// exposure, then streams the frame out over a valid/ready pixel port.
module pixel_readout #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned ROW_PIXELS = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           expose,
   input  logic                           erase,
   input  logic                           nre1,
   input  logic                           nre2,
   input  logic                           adc,
   input  logic [ROW_PIXELS*DATA_W-1:0]   adc_data,
   output logic [DATA_W-1:0]              pix_data,
   output logic                           pix_valid,
   input  logic                           pix_ready,
   output logic                           pix_last,
   output logic                           busy,
   output logic                           err,
   output logic                           overrun,
   input  logic                           err_clr
);

   localparam int unsigned NPIX  = 2 * ROW_PIXELS;
   localparam int unsigned ROW_W = ROW_PIXELS * DATA_W;
   localparam int unsigned IDX_W = $clog2(NPIX);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_EXPOSE  = 3'd1;
   localparam logic [2:0] S_READ_R1 = 3'd2;
   localparam logic [2:0] S_READ_R2 = 3'd3;
   localparam logic [2:0] S_STREAM  = 3'd4;

   logic [2:0]        state_q, state_d;
   logic              adc_q;
   logic [ROW_W-1:0]  row0_q, row0_d;
   logic [ROW_W-1:0]  row1_q, row1_d;
   logic [IDX_W-1:0]  idx_q, idx_d, idx_inc;
   logic              expose_blk_q, expose_blk_d;
   logic [DATA_W-1:0] pix_data_d;
   logic              pix_valid_d, pix_last_d, busy_d, err_d, overrun_d;
   logic              err_set, ovr_set;
   logic              adc_edge;
   logic [DATA_W-1:0] pix_arr [NPIX];

   assign adc_edge = adc & ~adc_q;
   assign idx_inc  = idx_q + IDX_W'(1);

   // Flatten both row buffers into frame order: row0 pixels, then row1 pixels.
   always_comb begin
      for (int i = 0; i < int'(ROW_PIXELS); i++) begin
         pix_arr[i]              = row0_q[i*DATA_W +: DATA_W];
         pix_arr[i + ROW_PIXELS] = row1_q[i*DATA_W +: DATA_W];
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      row0_d       = row0_q;
      row1_d       = row1_q;
      idx_d        = idx_q;
      pix_data_d   = pix_data;
      pix_valid_d  = pix_valid;
      pix_last_d   = pix_last;
      err_set      = 1'b0;
      ovr_set      = 1'b0;
      // An expose seen during streaming must drop before it can start a new frame.
      expose_blk_d = expose_blk_q & expose;

      case (state_q)
         S_IDLE: begin
            if (adc_edge) err_set = 1'b1;
            if (expose && !erase && !expose_blk_q) state_d = S_EXPOSE;
         end
         S_EXPOSE: begin
            if (adc_edge) err_set = 1'b1;
            if (erase) state_d = S_IDLE;
            else if (!expose) state_d = S_READ_R1;
         end
         S_READ_R1: begin
            if (erase) begin
               state_d = S_IDLE;
               err_set = 1'b1;
            end else if (adc_edge) begin
               if (!nre1 && nre2) begin
                  row0_d  = adc_data;
                  state_d = S_READ_R2;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         S_READ_R2: begin
            if (erase) begin
               state_d = S_IDLE;
               err_set = 1'b1;
            end else if (adc_edge) begin
               if (!nre2 && nre1) begin
                  row1_d      = adc_data;
                  state_d     = S_STREAM;
                  idx_d       = '0;
                  pix_data_d  = row0_q[DATA_W-1:0];
                  pix_valid_d = 1'b1;
                  pix_last_d  = 1'b0;
               end else begin
                  err_set = 1'b1;
               end
            end
         end
         S_STREAM: begin
            if (expose) begin
               ovr_set      = 1'b1;
               expose_blk_d = 1'b1;
            end
            if (pix_valid && pix_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d     = S_IDLE;
                  pix_valid_d = 1'b0;
                  pix_last_d  = 1'b0;
                  idx_d       = '0;
               end else begin
                  idx_d      = idx_inc;
                  pix_data_d = pix_arr[idx_inc];
                  pix_last_d = (idx_inc == LAST_IDX);
               end
            end
         end
         default: begin
            state_d     = S_IDLE;
            pix_valid_d = 1'b0;
            pix_last_d  = 1'b0;
         end
      endcase

      busy_d    = (state_d != S_IDLE);
      err_d     = err_set | (err & ~err_clr);
      overrun_d = ovr_set | (overrun & ~err_clr);
   end

   // State, buffers and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         adc_q        <= 1'b0;
         row0_q       <= '0;
         row1_q       <= '0;
         idx_q        <= '0;
         expose_blk_q <= 1'b0;
         pix_data     <= '0;
         pix_valid    <= 1'b0;
         pix_last     <= 1'b0;
         busy         <= 1'b0;
         err          <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         state_q      <= state_d;
         adc_q        <= adc;
         row0_q       <= row0_d;
         row1_q       <= row1_d;
         idx_q        <= idx_d;
         expose_blk_q <= expose_blk_d;
         pix_data     <= pix_data_d;
         pix_valid    <= pix_valid_d;
         pix_last     <= pix_last_d;
         busy         <= busy_d;
         err          <= err_d;
         overrun      <= overrun_d;
      end
   end

endmodule

// File: doc/pixel_readout.md
PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 Parameter DATA_W, default 8, bit width of one pixel sample.
REQ-002 Parameter ROW_PIXELS, default 2, number of pixels per row; a frame is 2 rows.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 expose  input  1  exposure strobe from the camera controller.
REQ-006 erase  input  1  erase strobe from the camera controller.
REQ-007 nre1  input  1  row-1 read enable, active low.
REQ-008 nre2  input  1  row-2 read enable, active low.
REQ-009 adc  input  1  ADC sample strobe.
REQ-010 adc_data  input  ROW_PIXELS*DATA_W  one converted row; pixel 0 sits in the LSBs.
REQ-011 pix_data  output  DATA_W  streamed pixel.
REQ-012 pix_valid  output  1  pix_data valid.
REQ-013 pix_ready  input  1  downstream accept.
REQ-014 pix_last  output  1  marks the final pixel of a frame.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 err  output  1  sticky protocol-error flag.
REQ-017 overrun  output  1  sticky flag: an exposure started while a frame was still streaming.
REQ-018 err_clr  input  1  synchronous clear of err and overrun.

Function
REQ-019 The block SHALL implement the states IDLE, EXPOSE, READ_R1, READ_R2 and STREAM.
REQ-020 IDLE->EXPOSE when expose=1 and erase=0.
REQ-021 EXPOSE->READ_R1 when expose=0 and erase=0.
REQ-022 EXPOSE->IDLE when erase=1; err is not set.
REQ-023 A valid sample SHALL be defined as the first cycle of an adc pulse, detected as a rising edge from a registered copy of adc.
REQ-024 In READ_R1, a valid sample with nre1=0 and nre2=1 SHALL store adc_data into row buffer 0 and move the FSM to READ_R2.
REQ-025 In READ_R2, a valid sample with nre2=0 and nre1=1 SHALL store adc_data into row buffer 1 and move the FSM to STREAM.
REQ-026 A valid sample with nre1=nre2 (both high or both low), or with the wrong row enabled for the current state, SHALL be discarded, set err, and leave the state unchanged.
REQ-027 A valid sample in IDLE or EXPOSE SHALL set err and be discarded.
REQ-028 erase=1 in READ_R1 or READ_R2 SHALL abort the frame to IDLE and set err.
REQ-029 pix_valid SHALL assert on the first cycle in STREAM, i.e. one cycle after the row-2 sample edge.
REQ-030 Pixels SHALL stream in the order row0 pix0..ROW_PIXELS-1, then row1 pix0..ROW_PIXELS-1.
REQ-031 pix_data and pix_valid SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-032 A pixel transfers on a cycle with pix_valid=1 and pix_ready=1.
REQ-033 pix_last=1 only with the 2*ROW_PIXELS-th pixel.
REQ-034 When the last pixel transfers, the FSM SHALL return to IDLE and pix_valid SHALL deassert the next cycle.
REQ-035 expose=1 during STREAM SHALL set overrun and SHALL NOT capture a new frame.
- The stream continues to completion.
- After completion the FSM goes to IDLE; a new exposure requires a fresh expose assertion from IDLE.
REQ-036 When err_clr=1 and a new error occur in the same cycle, set wins.
REQ-037 The pixel index counter SHALL be sized clog2(2*ROW_PIXELS) bits and SHALL NOT wrap within a frame.
REQ-038 All outputs SHALL be registered.

Reset
REQ-039 While reset=1, asynchronously: state=IDLE, pix_valid=0, pix_last=0, pix_data=0, busy=0, err=0, overrun=0, row buffers=0, adc edge register=0.
REQ-040 Reset asserted mid-frame or mid-stream SHALL discard the frame; no pixel is emitted after release until a full new frame is captured.

Verification
REQ-041 Nominal frame: expose 15 cycles; nre1 low with one adc pulse, data 0x2211; nre2 low with one adc pulse, data 0x4433; pix_ready=1 -> pixels 0x11, 0x22, 0x33, 0x44 on consecutive cycles, pix_last on 0x44, err=0.
REQ-042 Backpressure: same frame with pix_ready low for 3 cycles on pixel 2 -> 0x33 held stable, then the sequence completes with no loss or duplication.
REQ-043 Protocol error: adc pulse in READ_R1 with nre1=nre2=0 -> err=1 and state stays READ_R1; a later valid row-1 and row-2 pair still streams correctly.
REQ-044 Abort: erase=1 in READ_R2 -> IDLE, err=1, no pix_valid; err_clr pulse -> err=0.
REQ-045 Overrun: expose rises during STREAM -> overrun=1, current frame completes, FSM returns to IDLE.
REQ-046 Reset between the two pixel transfers -> all outputs 0 immediately; no further pixels until a full new frame is captured.
